// File: rtl/demux_rr_scheduler_if.sv
// Handshake bundle between producer, scheduler and the N consumers.
// The scheduler binds the slave modport; the environment binds master.
interface demux_rr_scheduler_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  localparam int SW = $clog2(N);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [N-1:0]  chan_en;
  logic [N-1:0]  out_valid;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_ready;
  logic [SW-1:0] sel;
  logic          busy;

  modport master (
    output in_valid, in_data, chan_en, out_ready,
    input  in_ready, out_valid, out_data, sel, busy
  );

  modport slave (
    input  in_valid, in_data, chan_en, out_ready,
    output in_ready, out_valid, out_data, sel, busy
  );
endinterface

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler steering one valid/ready stream to N channels.
// DEMUX_RR_SCHEDULER_TIMEOUT_EN adds stall-timeout redirect + timeout_evt.
module demux_rr_scheduler #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
`ifdef DEMUX_RR_SCHEDULER_TIMEOUT_EN
  output logic timeout_evt,
`endif
  demux_rr_scheduler_if.slave bus
);

  localparam int SW = $clog2(N);

  if (N < 2 || N > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("demux_rr_scheduler: parameter out of range");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t        r_state, w_state;
  logic [DW-1:0] r_data, w_data;
  logic [SW-1:0] r_sel, w_sel;
  logic [SW-1:0] r_ptr, w_ptr;
  logic [SW-1:0] w_sel_inc;
  logic [SW-1:0] w_pk_ptr, w_pk_nxt;
  logic          w_pk_ptr_ok, w_pk_nxt_ok;
  logic          w_hs, w_rdy;
  logic [N-1:0]  w_ov;

`ifdef DEMUX_RR_SCHEDULER_TIMEOUT_EN
  logic [7:0] r_stall, w_stall;
  logic       r_evt, w_evt;
`endif

  // First enabled channel at or cyclically after start; MSB = found.
  function automatic logic [SW:0] pick(
    input logic [SW-1:0] start,
    input logic [N-1:0]  en
  );
    logic [SW:0]   res;
    logic [SW-1:0] idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = SW'((int'(start) + k) % N);
      if (en[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_sel_inc = (int'(r_sel) == N - 1) ? '0 : r_sel + SW'(1);

  assign {w_pk_ptr_ok, w_pk_ptr} = pick(r_ptr, bus.chan_en);
  assign {w_pk_nxt_ok, w_pk_nxt} = pick(w_sel_inc, bus.chan_en);

  assign w_hs = bus.out_ready[r_sel];

  always_comb begin
    w_state = r_state;
    w_data  = r_data;
    w_sel   = r_sel;
    w_ptr   = r_ptr;
    w_rdy   = 1'b0;
`ifdef DEMUX_RR_SCHEDULER_TIMEOUT_EN
    w_stall = r_stall;
    w_evt   = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        w_rdy = w_pk_ptr_ok;
        if (bus.in_valid && w_rdy) begin
          w_state = SEND;
          w_data  = bus.in_data;
          w_sel   = w_pk_ptr;
`ifdef DEMUX_RR_SCHEDULER_TIMEOUT_EN
          w_stall = '0;
`endif
        end
      end
      SEND: begin
        w_rdy = w_hs && w_pk_nxt_ok;
        if (w_hs) begin
          w_ptr = w_sel_inc;
          if (bus.in_valid && w_rdy) begin
            w_data = bus.in_data;
            w_sel  = w_pk_nxt;
          end else begin
            w_state = IDLE;
          end
`ifdef DEMUX_RR_SCHEDULER_TIMEOUT_EN
          w_stall = '0;
`endif
        end
`ifdef DEMUX_RR_SCHEDULER_TIMEOUT_EN
        else begin
          // Saturate at TIMEOUT so a late-enabled channel redirects at once.
          if (r_stall < 8'(TIMEOUT)) w_stall = r_stall + 8'd1;
          if ((w_stall >= 8'(TIMEOUT) || !bus.chan_en[r_sel]) &&
              w_pk_nxt_ok && w_pk_nxt != r_sel) begin
            w_sel   = w_pk_nxt;
            w_stall = '0;
            w_evt   = 1'b1;
          end
        end
`endif
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state;
      r_data  <= w_data;
      r_sel   <= w_sel;
      r_ptr   <= w_ptr;
    end
  end

`ifdef DEMUX_RR_SCHEDULER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
      r_evt   <= 1'b0;
    end else begin
      r_stall <= w_stall;
      r_evt   <= w_evt;
    end
  end

  assign timeout_evt = r_evt;
`endif

  always_comb begin
    w_ov = '0;
    if (r_state == SEND) w_ov[r_sel] = 1'b1;
  end

  assign bus.in_ready  = w_rdy && !rst;
  assign bus.out_valid = w_ov;
  assign bus.out_data  = r_data;
  assign bus.sel       = r_sel;
  assign bus.busy      = (r_state == SEND);

endmodule
